// File: rtl/pet_state_controller.sv
// Game-state sequencer for the pet core. It divides clk into game ticks, ages the
// food and joy stats, and steps the ALIVE/EATING/PLAYING/SICK/DEAD machine.
module pet_state_controller #(
  parameter int TICK_DIV   = 1000,
  parameter int MAX_STAT   = 15,
  parameter int STAT_W     = 4,
  parameter int ACT_TICKS  = 4,
  parameter int SICK_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              feed_btn,
  input  logic              play_btn,
  output logic [STAT_W-1:0] food,
  output logic [STAT_W-1:0] joy,
  output logic [2:0]        state,
  output logic              busy,
  output logic              tick
);

  localparam int DIV_W  = $clog2(TICK_DIV);
  localparam int ACT_W  = $clog2(ACT_TICKS + 1);
  localparam int SICK_W = $clog2(SICK_LIMIT + 1);
  localparam logic [STAT_W-1:0] MAX_S = MAX_STAT[STAT_W-1:0];
  localparam logic [STAT_W:0]   MAX_X = MAX_STAT[STAT_W:0];

  typedef enum logic [2:0] {
    ALIVE   = 3'd0,
    EATING  = 3'd1,
    PLAYING = 3'd2,
    SICK    = 3'd3,
    DEAD    = 3'd4
  } state_t;

  state_t             st_q, st_n;
  logic [DIV_W-1:0]   div_q, div_n;
  logic [ACT_W-1:0]   act_q, act_n;
  logic [SICK_W-1:0]  sick_q, sick_n;
  logic [STAT_W-1:0]  food_q, food_n, joy_q, joy_n;
  logic               parity_q, parity_n;
  logic               feed_q, play_q;
  logic               tick_now, fe, pe, busy_n;
  logic [STAT_W-1:0]  food_dec, joy_dec, food_inc, joy_inc;
  logic [STAT_W:0]    food_sum, joy_sum;

  assign tick_now = ena && (div_q == DIV_W'(TICK_DIV - 1));
  assign fe       = ena & feed_btn & ~feed_q;
  assign pe       = ena & play_btn & ~play_q;

  // Saturating stat arithmetic; sums use one extra bit so the clamp sees overflow.
  assign food_dec = (food_q == '0) ? '0 : food_q - STAT_W'(1);
  assign joy_dec  = (joy_q == '0) ? '0 : joy_q - STAT_W'(1);
  assign food_sum = {1'b0, food_q} + (STAT_W+1)'(2);
  assign joy_sum  = {1'b0, joy_q} + (STAT_W+1)'(2);
  assign food_inc = (food_sum > MAX_X) ? MAX_S : food_sum[STAT_W-1:0];
  assign joy_inc  = (joy_sum > MAX_X) ? MAX_S : joy_sum[STAT_W-1:0];

  always_comb begin
    st_n     = st_q;
    act_n    = act_q;
    sick_n   = sick_q;
    food_n   = food_q;
    joy_n    = joy_q;
    parity_n = parity_q;
    div_n    = div_q;
    if (ena) div_n = tick_now ? '0 : div_q + DIV_W'(1);
    case (st_q)
      ALIVE: begin
        if (tick_now) begin
          food_n   = food_dec;
          parity_n = ~parity_q;
          if (parity_q) joy_n = joy_dec;
        end
        if (fe) begin
          st_n  = EATING;
          act_n = ACT_W'(ACT_TICKS);
        end else if (pe) begin
          st_n  = PLAYING;
          act_n = ACT_W'(ACT_TICKS);
        end else if (tick_now && (food_n == '0 || joy_n == '0)) begin
          st_n   = SICK;
          sick_n = '0;
        end
      end
      EATING: begin
        if (tick_now) begin
          food_n = food_inc;
          act_n  = act_q - ACT_W'(1);
          if (act_q == ACT_W'(1)) st_n = ALIVE;
        end
      end
      PLAYING: begin
        if (tick_now) begin
          joy_n  = joy_inc;
          food_n = food_dec;
          act_n  = act_q - ACT_W'(1);
          if (act_q == ACT_W'(1)) st_n = ALIVE;
        end
      end
      SICK: begin
        if (tick_now) begin
          sick_n = sick_q + SICK_W'(1);
          if (sick_q == SICK_W'(SICK_LIMIT - 1)) st_n = DEAD;
        end
        // Feeding rescues the pet even on the tick that would kill it.
        if (fe) begin
          st_n  = EATING;
          act_n = ACT_W'(ACT_TICKS);
        end
      end
      DEAD:    ;
      default: st_n = ALIVE;
    endcase
    busy_n = (st_n == EATING) || (st_n == PLAYING);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= ALIVE;
      div_q    <= '0;
      act_q    <= '0;
      sick_q   <= '0;
      food_q   <= MAX_S;
      joy_q    <= MAX_S;
      parity_q <= 1'b0;
      feed_q   <= 1'b0;
      play_q   <= 1'b0;
      busy     <= 1'b0;
      tick     <= 1'b0;
    end else begin
      st_q     <= st_n;
      div_q    <= div_n;
      act_q    <= act_n;
      sick_q   <= sick_n;
      food_q   <= food_n;
      joy_q    <= joy_n;
      parity_q <= parity_n;
      feed_q   <= feed_btn;
      play_q   <= play_btn;
      busy     <= busy_n;
      tick     <= tick_now;
    end
  end

  assign food  = food_q;
  assign joy   = joy_q;
  assign state = st_q;

endmodule
